// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier/accumulator datapath blocks.
package mult_pkg;

    // Default widths: 4x4 multiplier product and vector-length counter.
    localparam int unsigned ProdWidth = 8;
    localparam int unsigned LenWidth  = 4;
    localparam int unsigned AccWidth  = ProdWidth + LenWidth;

    // Accumulator control states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAcc  = 2'd1,
        StOut  = 2'd2
    } acc_state_e;

endpackage

// File: rtl/product_accumulator_if.sv
// Term input and result output handshakes of the product accumulator.
interface product_accumulator_if
    import mult_pkg::*;
#(
    parameter int unsigned PW = ProdWidth,
    parameter int unsigned AW = AccWidth
);
    logic [PW-1:0] prod_i;
    logic          prod_valid;
    logic          prod_ready;
    logic [AW-1:0] sum_o;
    logic          sum_valid;
    logic          sum_ready;

    // Upstream/downstream side: supplies terms, consumes the sum.
    modport master (
        output prod_i,
        output prod_valid,
        input  prod_ready,
        input  sum_o,
        input  sum_valid,
        output sum_ready
    );

    // Accumulator side.
    modport slave (
        input  prod_i,
        input  prod_valid,
        output prod_ready,
        output sum_o,
        output sum_valid,
        input  sum_ready
    );
endinterface

// File: rtl/main.sv
// 4x4 unsigned multiplier feeding the accumulator.
module main (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] o
);
    // Pure combinational product.
    always_comb begin
        o = 8'(a) * 8'(b);
    end
endmodule

// File: rtl/product_accumulator_ctrl.sv
// Control FSM for the product accumulator: IDLE -> ACC -> OUT.
module product_accumulator_ctrl
    import mult_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic abort_i,
    input  logic prod_valid_i,
    input  logic sum_ready_i,
    input  logic last_term_i,
    output logic load_o,
    output logic accept_o,
    output logic finish_o,
    output logic prod_ready_o,
    output logic sum_valid_o,
    output logic busy_o,
    output logic start_drop_o
);
    acc_state_e state_q, state_d;
    logic       start_drop_q, start_drop_d;

    // State and drop-pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            start_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_drop_q <= start_drop_d;
        end
    end

    // Next-state logic; abort overrides every other input outside IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                // Abort in IDLE also masks a simultaneous start.
                if (start_i && !abort_i) begin
                    state_d = StAcc;
                end
            end
            StAcc: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else if (prod_valid_i && last_term_i) begin
                    state_d = StOut;
                end
            end
            StOut: begin
                if (abort_i || sum_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs; sum_valid comes straight from state so it never depends on sum_ready.
    always_comb begin
        prod_ready_o = (state_q == StAcc) && !abort_i;
        accept_o     = prod_ready_o && prod_valid_i;
        finish_o     = accept_o && last_term_i;
        load_o       = (state_q == StIdle) && start_i && !abort_i;
        sum_valid_o  = (state_q == StOut);
        busy_o       = (state_q != StIdle);
        start_drop_d = start_i && (state_q != StIdle);
        start_drop_o = start_drop_q;
    end
endmodule

// File: rtl/product_accumulator.sv
// Accumulates a vector of multiplier products and hands out the sum.
module product_accumulator
    import mult_pkg::*;
#(
    parameter int unsigned PW = ProdWidth,
    parameter int unsigned LW = LenWidth,
    parameter int unsigned AW = PW + LW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] len_m1,
    input  logic          abort,
    output logic          busy,
    output logic          start_drop,
    product_accumulator_if.slave bus_io
);
    logic [AW-1:0] acc_q, acc_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] len_q, len_d;
    logic [AW-1:0] sum_q, sum_d;
    logic [AW-1:0] acc_next;
    logic          load, accept, finish, last_term;
    logic          prod_ready, sum_valid;

    // cnt never needs to pass len_q: the last term leaves ACC before it would wrap.
    assign last_term = (cnt_q == len_q);
    assign acc_next  = acc_q + AW'(bus_io.prod_i);

    product_accumulator_ctrl u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .abort_i      (abort),
        .prod_valid_i (bus_io.prod_valid),
        .sum_ready_i  (bus_io.sum_ready),
        .last_term_i  (last_term),
        .load_o       (load),
        .accept_o     (accept),
        .finish_o     (finish),
        .prod_ready_o (prod_ready),
        .sum_valid_o  (sum_valid),
        .busy_o       (busy),
        .start_drop_o (start_drop)
    );

    // Datapath next-state: clear on start, add on each accepted term.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        len_d = len_q;
        sum_d = sum_q;
        if (load) begin
            acc_d = '0;
            cnt_d = '0;
            len_d = len_m1;
        end else if (accept) begin
            acc_d = acc_next;
            cnt_d = cnt_q + LW'(1);
            if (finish) begin
                sum_d = acc_next;
            end
        end
    end

    // Datapath registers; sum_q holds its value through IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            len_q <= '0;
            sum_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            len_q <= len_d;
            sum_q <= sum_d;
        end
    end

    assign bus_io.prod_ready = prod_ready;
    assign bus_io.sum_valid  = sum_valid;
    assign bus_io.sum_o      = sum_q;
endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench: multiplier -> product_accumulator, hand-computed sums.
module tb_product_accumulator;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] len_m1 = 4'd0;
    logic       abort = 1'b0;
    logic       busy;
    logic       start_drop;
    logic [3:0] mult_a = 4'd0;
    logic [3:0] mult_b = 4'd0;

    int n_checks = 0;
    int n_fail   = 0;

    product_accumulator_if #(.PW(8), .AW(12)) bus_if ();

    main u_mult (
        .a (mult_a),
        .b (mult_b),
        .o (bus_if.prod_i)
    );

    product_accumulator #(.PW(8), .LW(4), .AW(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len_m1     (len_m1),
        .abort      (abort),
        .busy       (busy),
        .start_drop (start_drop),
        .bus_io     (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a run and feed terms a*(b0 + k*bstep) under the valid pattern
    // (pattern bit i applies in ACC cycle i, valid=1 afterwards).
    task automatic run_accum(input logic [3:0] len, input logic [3:0] a, input logic [3:0] b0,
                             input bit bstep, input logic [31:0] vpat, input int vlen,
                             output int accepts, output bit last_acc, output bit ok);
        bit took;
        accepts  = 0;
        last_acc = 1'b0;
        ok       = 1'b0;
        bus_if.prod_valid = 1'b0;
        start  = 1'b1;
        len_m1 = len;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            mult_a = a;
            mult_b = b0 + (bstep ? 4'(accepts) : 4'd0);
            bus_if.prod_valid = (cyc < vlen) ? vpat[cyc] : 1'b1;
            #1;
            took = bus_if.prod_ready && bus_if.prod_valid;
            if (took) accepts++;
            tick();
            if (bus_if.sum_valid) begin
                last_acc = took;
                ok = 1'b1;
                break;
            end
        end
        bus_if.prod_valid = 1'b0;
    endtask

    task automatic release_sum();
        bus_if.sum_ready = 1'b1;
        tick();
        bus_if.sum_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        n_checks++; if (bus_if.sum_o !== 12'd0) begin n_fail++; $display("FAIL reset_sum_o: got %0d want 0", bus_if.sum_o); end
        n_checks++; if (bus_if.sum_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sum_valid: got %b want 0", bus_if.sum_valid); end
        n_checks++; if (bus_if.prod_ready !== 1'b0) begin n_fail++; $display("FAIL reset_prod_ready: got %b want 0", bus_if.prod_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (start_drop !== 1'b0) begin n_fail++; $display("FAIL reset_start_drop: got %b want 0", start_drop); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_three_terms();
        int acc_n; bit last_acc; bit ok;
        run_accum(4'd2, 4'd15, 4'd15, 1'b0, 32'h0, 0, acc_n, last_acc, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL three_timeout: sum_valid not seen within bound"); end
        n_checks++; if (acc_n !== 3) begin n_fail++; $display("FAIL three_accepts: got %0d want 3", acc_n); end
        n_checks++; if (!last_acc) begin n_fail++; $display("FAIL three_latency: sum_valid not 1 cycle after last accept"); end
        n_checks++; if (bus_if.sum_o !== 12'h2A3) begin n_fail++; $display("FAIL three_sum: got %0d want 675", bus_if.sum_o); end
        n_checks++; if (bus_if.prod_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL three_out_flags: prod_ready=%b busy=%b want 0/1", bus_if.prod_ready, busy); end
        release_sum();
        n_checks++; if (bus_if.sum_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL three_release: sum_valid=%b busy=%b want 0/0", bus_if.sum_valid, busy); end
        n_checks++; if (bus_if.sum_o !== 12'd675) begin n_fail++; $display("FAIL three_hold_idle: got %0d want 675", bus_if.sum_o); end
    endtask

    task automatic test_full_and_single();
        int acc_n; bit last_acc; bit ok;
        run_accum(4'd15, 4'd15, 4'd15, 1'b0, 32'h0, 0, acc_n, last_acc, ok);
        n_checks++; if (!ok || acc_n !== 16) begin n_fail++; $display("FAIL full_accepts: got %0d ok=%b want 16", acc_n, ok); end
        n_checks++; if (bus_if.sum_o !== 12'hE10) begin n_fail++; $display("FAIL full_sum: got %0d want 3600", bus_if.sum_o); end
        release_sum();
        run_accum(4'd0, 4'd2, 4'd3, 1'b0, 32'h0, 0, acc_n, last_acc, ok);
        n_checks++; if (!ok || acc_n !== 1 || !last_acc) begin n_fail++; $display("FAIL single_accepts: got %0d ok=%b lat=%b want 1", acc_n, ok, last_acc); end
        n_checks++; if (bus_if.sum_o !== 12'd6) begin n_fail++; $display("FAIL single_sum: got %0d want 6", bus_if.sum_o); end
        release_sum();
    endtask

    task automatic test_gappy();
        int acc_n; bit last_acc; bit ok;
        // valid pattern 1,0,0,1,0,1 with terms 1*1, 1*2, 1*3
        run_accum(4'd2, 4'd1, 4'd1, 1'b1, 32'b101001, 6, acc_n, last_acc, ok);
        n_checks++; if (!ok || acc_n !== 3) begin n_fail++; $display("FAIL gappy_accepts: got %0d ok=%b want 3", acc_n, ok); end
        n_checks++; if (bus_if.sum_o !== 12'd6) begin n_fail++; $display("FAIL gappy_sum: got %0d want 6", bus_if.sum_o); end
        release_sum();
    endtask

    task automatic test_out_hold_and_drop();
        int acc_n; bit last_acc; bit ok;
        run_accum(4'd0, 4'd5, 4'd5, 1'b0, 32'h0, 0, acc_n, last_acc, ok);
        n_checks++; if (!ok || bus_if.sum_o !== 12'd25) begin n_fail++; $display("FAIL hold_sum: got %0d ok=%b want 25", bus_if.sum_o, ok); end
        for (int i = 0; i < 4; i++) begin
            start  = (i == 0);
            len_m1 = 4'd3;
            tick();
            n_checks++; if (bus_if.sum_valid !== 1'b1 || bus_if.sum_o !== 12'd25) begin n_fail++; $display("FAIL hold_stable_%0d: valid=%b sum=%0d want 1/25", i, bus_if.sum_valid, bus_if.sum_o); end
            n_checks++; if (start_drop !== (i == 0)) begin n_fail++; $display("FAIL hold_start_drop_%0d: got %b want %b", i, start_drop, (i == 0)); end
        end
        start = 1'b0;
        release_sum();
        tick();
        n_checks++; if (busy !== 1'b0 || bus_if.sum_valid !== 1'b0) begin n_fail++; $display("FAIL hold_no_new_run: busy=%b valid=%b want 0/0", busy, bus_if.sum_valid); end
    endtask

    task automatic test_abort();
        int acc_n; bit last_acc; bit ok; bit saw_valid;
        start  = 1'b1;
        len_m1 = 4'd3;
        mult_a = 4'd15;
        mult_b = 4'd15;
        tick();
        start = 1'b0;
        bus_if.prod_valid = 1'b1;
        tick();
        tick();
        abort = 1'b1;
        #1;
        n_checks++; if (bus_if.prod_ready !== 1'b0) begin n_fail++; $display("FAIL abort_prod_ready: got %b want 0", bus_if.prod_ready); end
        tick();
        abort = 1'b0;
        bus_if.prod_valid = 1'b0;
        n_checks++; if (busy !== 1'b0 || bus_if.sum_valid !== 1'b0) begin n_fail++; $display("FAIL abort_idle: busy=%b valid=%b want 0/0", busy, bus_if.sum_valid); end
        saw_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus_if.sum_valid) saw_valid = 1'b1;
        end
        n_checks++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL abort_no_valid: got %b want 0", saw_valid); end
        // abort in IDLE masks a simultaneous start
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle_start: busy=%b want 0", busy); end
        run_accum(4'd0, 4'd3, 4'd3, 1'b0, 32'h0, 0, acc_n, last_acc, ok);
        n_checks++; if (!ok || acc_n !== 1 || bus_if.sum_o !== 12'd9) begin n_fail++; $display("FAIL abort_rerun: sum=%0d accepts=%0d want 9/1", bus_if.sum_o, acc_n); end
        release_sum();
    endtask

    task automatic test_reset_mid();
        int acc_n; bit last_acc; bit ok; bit saw_valid;
        start  = 1'b1;
        len_m1 = 4'd5;
        mult_a = 4'd7;
        mult_b = 4'd7;
        tick();
        start = 1'b0;
        bus_if.prod_valid = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_checks++; if (bus_if.sum_o !== 12'd0 || bus_if.sum_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_sum: sum=%0d valid=%b want 0/0", bus_if.sum_o, bus_if.sum_valid); end
        n_checks++; if (bus_if.prod_ready !== 1'b0 || busy !== 1'b0 || start_drop !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags: ready=%b busy=%b drop=%b want 0/0/0", bus_if.prod_ready, busy, start_drop); end
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus_if.sum_valid || busy) saw_valid = 1'b1;
        end
        bus_if.prod_valid = 1'b0;
        n_checks++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_valid: got %b want 0", saw_valid); end
        run_accum(4'd1, 4'd4, 4'd4, 1'b0, 32'h0, 0, acc_n, last_acc, ok);
        n_checks++; if (!ok || acc_n !== 2 || bus_if.sum_o !== 12'd32) begin n_fail++; $display("FAIL rstmid_rerun: sum=%0d accepts=%0d want 32/2", bus_if.sum_o, acc_n); end
        release_sum();
    endtask

    initial begin
        bus_if.prod_valid = 1'b0;
        bus_if.sum_ready  = 1'b0;
        test_reset();
        test_three_terms();
        test_full_and_single();
        test_gappy();
        test_out_hold_and_drop();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
